// File: rtl/multiway_traffic_controller.sv
// N-approach traffic-light controller with built-in countdown timer.
// Round-robin car service, green extension, yellow/all-red clearance, batched walk.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   car        per-approach car-present level sensor
//   ped        per-crosswalk button (pulse or level)
//   light      per approach [3i+2:3i]: 001 red, 010 yellow, 100 green
//   walk       per-crosswalk walk lamp
//   phase      00 ALLRED, 01 GREEN, 10 YELLOW, 11 PED
//   active_dir approach owning GREEN/YELLOW (holds last value otherwise)
//   timer_out  current countdown value
module multiway_traffic_controller #(
   parameter int N_DIR    = 4,
   parameter int TW       = 8,
   parameter int GREEN_T  = 10,
   parameter int YELLOW_T = 3,
   parameter int ALLRED_T = 2,
   parameter int PED_T    = 15,
   localparam int DW      = (N_DIR > 2) ? $clog2(N_DIR) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_DIR-1:0]     car,
   input  logic [N_DIR-1:0]     ped,
   output logic [3*N_DIR-1:0]   light,
   output logic [N_DIR-1:0]     walk,
   output logic [1:0]           phase,
   output logic [DW-1:0]        active_dir,
   output logic [TW-1:0]        timer_out
);

   typedef enum logic [1:0] {
      ALLRED = 2'b00,
      GREEN  = 2'b01,
      YELLOW = 2'b10,
      PED    = 2'b11
   } state_t;

   localparam logic [TW-1:0] G_LD = TW'(GREEN_T - 1);
   localparam logic [TW-1:0] Y_LD = TW'(YELLOW_T - 1);
   localparam logic [TW-1:0] A_LD = TW'(ALLRED_T - 1);
   localparam logic [TW-1:0] P_LD = TW'(PED_T - 1);

   state_t           state, state_n;
   logic [TW-1:0]    timer, timer_n;
   logic [DW-1:0]    last_served, last_n;
   logic [DW-1:0]    dir_n;
   logic [N_DIR-1:0] ped_pend, pend_n;
   logic [N_DIR-1:0] walk_snap, snap_n;

   logic             found;
   logic [DW-1:0]    pick;
   logic [N_DIR-1:0] own;
   logic [N_DIR-1:0] others;
   int               idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ALLRED;
         timer       <= A_LD;
         last_served <= DW'(N_DIR - 1);
         active_dir  <= '0;
         ped_pend    <= '0;
         walk_snap   <= '0;
      end else begin
         state       <= state_n;
         timer       <= timer_n;
         last_served <= last_n;
         active_dir  <= dir_n;
         ped_pend    <= pend_n;
         walk_snap   <= snap_n;
      end
   end

   // Round-robin pick: first requesting approach after last_served, wrapping.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int k = 1; k <= N_DIR; k++) begin
         idx = int'(last_served) + k;
         if (idx >= N_DIR) idx = idx - N_DIR;
         if (!found && car[idx]) begin
            found = 1'b1;
            pick  = DW'(idx);
         end
      end
   end

   always_comb begin
      own             = '0;
      own[active_dir] = 1'b1;
      others          = car & ~own;
   end

   always_comb begin
      state_n = state;
      timer_n = timer;
      last_n  = last_served;
      dir_n   = active_dir;
      pend_n  = ped_pend;
      snap_n  = walk_snap;
      if (state != PED) pend_n = ped_pend | ped;
      if (timer != '0) timer_n = timer - TW'(1);
      unique case (state)
         ALLRED: begin
            if (timer == '0) begin
               if (|ped_pend) begin
                  // A press landing on the entry edge joins this walk.
                  state_n = PED;
                  timer_n = P_LD;
                  snap_n  = ped_pend | ped;
                  pend_n  = '0;
               end else if (found) begin
                  state_n = GREEN;
                  timer_n = G_LD;
                  last_n  = pick;
                  dir_n   = pick;
               end
            end
         end
         GREEN: begin
            if (timer == '0) begin
               if (others == '0 && ped_pend == '0) begin
                  timer_n = G_LD;
               end else begin
                  state_n = YELLOW;
                  timer_n = Y_LD;
               end
            end
         end
         YELLOW: begin
            if (timer == '0) begin
               state_n = ALLRED;
               timer_n = A_LD;
            end
         end
         PED: begin
            if (timer == '0) begin
               state_n = ALLRED;
               timer_n = A_LD;
            end
         end
         default: begin
            state_n = ALLRED;
            timer_n = A_LD;
         end
      endcase
   end

   always_comb begin
      light = '0;
      for (int i = 0; i < N_DIR; i++) begin
         light[3*i +: 3] = 3'b001;
         if (active_dir == DW'(i)) begin
            if (state == GREEN)  light[3*i +: 3] = 3'b100;
            if (state == YELLOW) light[3*i +: 3] = 3'b010;
         end
      end
   end

   assign walk      = (state == PED) ? walk_snap : '0;
   assign phase     = state;
   assign timer_out = timer;

endmodule

// File: tb/tb_multiway_traffic_controller.sv
// Bench for multiway_traffic_controller.
// Directed scenarios plus random traffic against a reference model.
module tb_multiway_traffic_controller;

   localparam int N = 4;
   localparam int GT = 10, YT = 3, AT = 2, PT = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  car = '0;
   logic [3:0]  ped = '0;
   logic [11:0] light;
   logic [3:0]  walk;
   logic [1:0]  phase;
   logic [1:0]  active_dir;
   logic [7:0]  timer_out;

   multiway_traffic_controller dut (
      .clk        (clk),
      .rst        (rst),
      .car        (car),
      .ped        (ped),
      .light      (light),
      .walk       (walk),
      .phase      (phase),
      .active_dir (active_dir),
      .timer_out  (timer_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [11:0] light;
      logic [3:0]  walk;
      logic [1:0]  phase;
      logic [1:0]  dir;
      logic [7:0]  timer;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Model: phase code, cycles left in phase (incl. current), served dir.
   int         m_ph   = 0;
   int         m_left = AT;
   int         m_last = N - 1;
   int         m_dir  = 0;
   logic [3:0] m_pend = '0;
   logic [3:0] m_snap = '0;

   task automatic model_step(input logic r, input logic [3:0] c,
                             input logic [3:0] p);
      logic [3:0] np;
      logic [3:0] oth;
      int d;
      if (r) begin
         m_ph = 0; m_left = AT; m_last = N - 1;
         m_dir = 0; m_pend = '0; m_snap = '0;
         return;
      end
      np = (m_ph != 3) ? (m_pend | p) : m_pend;
      if (m_left > 1) begin
         m_left--;
      end else begin
         case (m_ph)
            0: begin
               if (m_pend != 0) begin
                  m_ph = 3; m_left = PT;
                  m_snap = m_pend | p; np = '0;
               end else if (c != 0) begin
                  for (int j = 1; j <= N; j++) begin
                     d = (m_last + j) % N;
                     if (c[d]) break;
                  end
                  m_ph = 1; m_left = GT; m_last = d; m_dir = d;
               end else begin
                  m_left = 1;
               end
            end
            1: begin
               oth = c;
               oth[m_dir] = 1'b0;
               if (oth == 0 && m_pend == 0) m_left = GT;
               else begin m_ph = 2; m_left = YT; end
            end
            default: begin m_ph = 0; m_left = AT; end
         endcase
      end
      m_pend = np;
   endtask

   function automatic exp_t model_out();
      exp_t e;
      for (int i = 0; i < N; i++) begin
         if (m_ph == 1 && m_dir == i)      e.light[3*i +: 3] = 3'b100;
         else if (m_ph == 2 && m_dir == i) e.light[3*i +: 3] = 3'b010;
         else                              e.light[3*i +: 3] = 3'b001;
      end
      e.walk  = (m_ph == 3) ? m_snap : 4'b0;
      e.phase = 2'(m_ph);
      e.dir   = 2'(m_dir);
      e.timer = 8'(m_left - 1);
      return e;
   endfunction

   task automatic cyc(input logic r, input logic [3:0] c, input logic [3:0] p);
      @(negedge clk);
      rst = r; car = c; ped = p;
      model_step(r, c, p);
      q.push_back(model_out());
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s @%0t: got %h want %h", nm, $time, act, req);
      end
   endtask

   // Monitor: pops one expectation per clock and checks invariants.
   initial begin
      exp_t e;
      int nr;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("light", 32'(light), 32'(e.light));
            chk("walk", 32'(walk), 32'(e.walk));
            chk("phase", 32'(phase), 32'(e.phase));
            chk("active_dir", 32'(active_dir), 32'(e.dir));
            chk("timer_out", 32'(timer_out), 32'(e.timer));
            nr = 0;
            for (int i = 0; i < N; i++)
               if (light[3*i +: 3] != 3'b001) nr++;
            chk("one_nonred", 32'(nr <= 1), 32'd1);
            chk("walk_only_ped", 32'(walk == 0 || phase == 2'b11), 32'd1);
         end
      end
   end

   initial begin
      logic [3:0] cr;
      logic [3:0] pr;
      logic       rr;
      int         guard;

      // Idle after reset: stays all-red.
      cyc(1, 4'h0, 4'h0);
      repeat (110) cyc(0, 4'h0, 4'h0);

      // Single requester gets extended green.
      cyc(1, 4'h0, 4'h0);
      repeat (60) cyc(0, 4'b0100, 4'h0);

      // All requesting: round robin.
      cyc(1, 4'h0, 4'h0);
      repeat (80) cyc(0, 4'b1111, 4'h0);

      // Ped press during green.
      cyc(1, 4'h0, 4'h0);
      repeat (12) cyc(0, 4'b0001, 4'h0);
      cyc(0, 4'b0001, 4'b0010);
      repeat (60) cyc(0, 4'b0001, 4'h0);

      // Ped and car pending together at all-red expiry.
      cyc(1, 4'h0, 4'h0);
      cyc(0, 4'b1000, 4'b0001);
      repeat (60) cyc(0, 4'b1000, 4'h0);

      // Reset during yellow with a pending walk.
      cyc(1, 4'h0, 4'h0);
      repeat (6) cyc(0, 4'b0001, 4'h0);
      cyc(0, 4'b0001, 4'b0100);
      guard = 0;
      while (!(m_ph == 2 && m_pend != 0) && guard < 100) begin
         cyc(0, 4'b0001, 4'h0);
         guard++;
      end
      chk("reach_yellow", 32'(guard < 100), 32'd1);
      cyc(1, 4'b0110, 4'h0);
      repeat (30) cyc(0, 4'b0110, 4'h0);

      // Random traffic.
      cr = 4'h0;
      for (int n = 0; n < 2500; n++) begin
         if ($urandom_range(0, 24) == 0) cr = 4'($urandom);
         pr = ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'h0;
         rr = ($urandom_range(0, 399) == 0);
         cyc(rr, cr, pr);
      end

      @(posedge clk);
      #3;
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
